// File: rtl/mem_access_stage_pkg.sv
// Shared constants, state encoding and helpers for the MEM stage.
package mem_access_stage_pkg;

    localparam int WDATA_SRC_LENGTH = 2;

    localparam logic [WDATA_SRC_LENGTH-1:0] WDATA_SRC_ALU = 2'b00;
    localparam logic [WDATA_SRC_LENGTH-1:0] WDATA_SRC_MEM = 2'b01;
    localparam logic [WDATA_SRC_LENGTH-1:0] WDATA_SRC_PC  = 2'b10;

    localparam logic [1:0]  INIT_2  = 2'b00;
    localparam logic [31:0] INIT_32 = 32'h0000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Drops the byte offset so the bus always sees a word address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register; a bubble clears every field so no write-back happens.
module mem_wb_reg
    import mem_access_stage_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bubble_i,
    input  logic [WDATA_SRC_LENGTH-1:0] wsrc_i,
    input  logic [31:0]                 alures_i,
    input  logic [31:0]                 memdata_i,
    input  logic [4:0]                  wreg_i,
    output logic [WDATA_SRC_LENGTH-1:0] wsrc_o,
    output logic [31:0]                 alures_o,
    output logic [31:0]                 memdata_o,
    output logic [4:0]                  wreg_o
);

    // Load the next write-back tuple, or clear it on reset or bubble.
    always_ff @(posedge clk) begin
        if (!rst || bubble_i) begin
            wsrc_o    <= INIT_2;
            alures_o  <= INIT_32;
            memdata_o <= INIT_32;
            wreg_o    <= 5'd0;
        end else begin
            wsrc_o    <= wsrc_i;
            alures_o  <= alures_i;
            memdata_o <= memdata_i;
            wreg_o    <= wreg_i;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory accesses over req/ack, stalls the
// pipeline while one is outstanding, and feeds the MEM/WB register.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        DataMemWE,
    input  logic [WDATA_SRC_LENGTH-1:0] WriteDataSrc,
    input  logic [31:0]                 ALURes,
    input  logic [31:0]                 Reg2DataOut,
    input  logic [4:0]                  WriteRegSrc,
    output logic                        dmem_req,
    output logic                        dmem_we,
    output logic [31:0]                 dmem_addr,
    output logic [31:0]                 dmem_wdata,
    input  logic [31:0]                 dmem_rdata,
    input  logic                        dmem_ack,
    output logic                        stall_req,
    output logic [WDATA_SRC_LENGTH-1:0] WriteDataSrc_out,
    output logic [31:0]                 ALURes_out,
    output logic [31:0]                 MemData_out,
    output logic [4:0]                  WriteRegSrc_out,
    output logic                        bus_err,
    output logic                        align_err
);

    state_t                      state_q, state_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic                        req_q, req_d;
    logic                        we_q, we_d;
    logic [31:0]                 addr_q, addr_d;
    logic [31:0]                 wdata_q, wdata_d;
    logic [4:0]                  wreg_q, wreg_d;
    logic [WDATA_SRC_LENGTH-1:0] wsrc_q, wsrc_d;
    logic                        busErr_q, busErr_d;
    logic                        alignErr_q, alignErr_d;

    logic                        acc;
    logic                        aligned;
    logic                        timeoutHit;

    logic                        wbBubble;
    logic [WDATA_SRC_LENGTH-1:0] wbWsrc;
    logic [31:0]                 wbAlu;
    logic [31:0]                 wbMem;
    logic [4:0]                  wbWreg;

    assign acc        = DataMemWE | (WriteDataSrc == WDATA_SRC_MEM);
    assign aligned    = (ALURes[1:0] == 2'b00);
    assign timeoutHit = (cnt_q == 8'(TIMEOUT - 1));

    // Next-state, bus and write-back selection for the access FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wreg_d     = wreg_q;
        wsrc_d     = wsrc_q;
        busErr_d   = 1'b0;
        alignErr_d = 1'b0;
        wbBubble   = 1'b0;
        wbWsrc     = WriteDataSrc;
        wbAlu      = ALURes;
        wbMem      = INIT_32;
        wbWreg     = WriteRegSrc;

        case (state_q)
            ST_IDLE: begin
                if (acc && !aligned) begin
                    alignErr_d = 1'b1;
                    wbWreg     = 5'd0;
                end else if (acc) begin
                    state_d  = ST_BUSY;
                    cnt_d    = 8'd0;
                    req_d    = 1'b1;
                    we_d     = DataMemWE;
                    addr_d   = word_align(ALURes);
                    wdata_d  = Reg2DataOut;
                    wreg_d   = WriteRegSrc;
                    wsrc_d   = WriteDataSrc;
                    wbBubble = 1'b1;
                end
            end
            ST_BUSY: begin
                wbBubble = 1'b1;
                if (dmem_ack) begin
                    state_d  = ST_IDLE;
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    wbBubble = 1'b0;
                    wbWsrc   = wsrc_q;
                    wbAlu    = addr_q;
                    wbWreg   = wreg_q;
                    wbMem    = we_q ? INIT_32 : dmem_rdata;
                end else if (timeoutHit) begin
                    state_d  = ST_IDLE;
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    busErr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    // State and latched-access registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= INIT_32;
            wdata_q    <= INIT_32;
            wreg_q     <= 5'd0;
            wsrc_q     <= INIT_2;
            busErr_q   <= 1'b0;
            alignErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wreg_q     <= wreg_d;
            wsrc_q     <= wsrc_d;
            busErr_q   <= busErr_d;
            alignErr_q <= alignErr_d;
        end
    end

    // Stall while busy, or while an aligned access is about to be launched.
    always_comb begin
        stall_req = rst & ((state_q == ST_BUSY) || (acc && aligned));
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign bus_err    = busErr_q;
    assign align_err  = alignErr_q;

    mem_wb_reg u_mem_wb_reg (
        .clk       (clk),
        .rst       (rst),
        .bubble_i  (wbBubble),
        .wsrc_i    (wbWsrc),
        .alures_i  (wbAlu),
        .memdata_i (wbMem),
        .wreg_i    (wbWreg),
        .wsrc_o    (WriteDataSrc_out),
        .alures_o  (ALURes_out),
        .memdata_o (MemData_out),
        .wreg_o    (WriteRegSrc_out)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a
// randomized transaction stream checked against a transaction-level model.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        DataMemWE;
    logic [1:0]  WriteDataSrc;
    logic [31:0] ALURes;
    logic [31:0] Reg2DataOut;
    logic [4:0]  WriteRegSrc;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall_req;
    logic [1:0]  WriteDataSrc_out;
    logic [31:0] ALURes_out;
    logic [31:0] MemData_out;
    logic [4:0]  WriteRegSrc_out;
    logic        bus_err;
    logic        align_err;

    int tests = 0;
    int fails = 0;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .DataMemWE        (DataMemWE),
        .WriteDataSrc     (WriteDataSrc),
        .ALURes           (ALURes),
        .Reg2DataOut      (Reg2DataOut),
        .WriteRegSrc      (WriteRegSrc),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_ack         (dmem_ack),
        .stall_req        (stall_req),
        .WriteDataSrc_out (WriteDataSrc_out),
        .ALURes_out       (ALURes_out),
        .MemData_out      (MemData_out),
        .WriteRegSrc_out  (WriteRegSrc_out),
        .bus_err          (bus_err),
        .align_err        (align_err)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // EXE/MEM bubble on the inputs.
    task automatic bubble();
        DataMemWE    = 1'b0;
        WriteDataSrc = 2'b00;
        ALURes       = 32'd0;
        Reg2DataOut  = 32'd0;
        WriteRegSrc  = 5'd0;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        DataMemWE    = 1'b1;
        WriteDataSrc = 2'b00;
        ALURes       = 32'h100;
        Reg2DataOut  = 32'h5555_AAAA;
        WriteRegSrc  = 5'd3;
        dmem_ack     = 1'b0;
        dmem_rdata   = 32'h0;
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, stall_req, WriteDataSrc_out,
                 ALURes_out, MemData_out, WriteRegSrc_out, bus_err, align_err} !== 140'd0) begin
                fails++;
                $display("[TB] FAIL reset_outputs cycle %0d: got req=%b we=%b addr=%h wdata=%h stall=%b wsrc=%h alu=%h mem=%h wreg=%h berr=%b aerr=%b, expected all 0",
                         i, dmem_req, dmem_we, dmem_addr, dmem_wdata, stall_req, WriteDataSrc_out,
                         ALURes_out, MemData_out, WriteRegSrc_out, bus_err, align_err);
            end
        end
        bubble();
        rst = 1'b1;
        step();
    endtask

    task automatic test_alu_pass();
        WriteDataSrc = 2'b00;
        ALURes       = 32'h1234;
        WriteRegSrc  = 5'd5;
        #1;
        tests++;
        if (stall_req !== 1'b0) begin
            fails++;
            $display("[TB] FAIL alu_stall: got %b expected 0", stall_req);
        end
        step();
        tests++;
        if ({WriteDataSrc_out, ALURes_out, MemData_out, WriteRegSrc_out, dmem_req, stall_req} !==
            {2'b00, 32'h1234, 32'h0, 5'd5, 1'b0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL alu_pass: got wsrc=%h alu=%h mem=%h wreg=%0d req=%b stall=%b expected wsrc=0 alu=1234 mem=0 wreg=5 req=0 stall=0",
                     WriteDataSrc_out, ALURes_out, MemData_out, WriteRegSrc_out, dmem_req, stall_req);
        end
        bubble();
        step();
    endtask

    task automatic test_load();
        WriteDataSrc = 2'b01;
        ALURes       = 32'h40;
        WriteRegSrc  = 5'd8;
        #1;
        tests++;
        if (stall_req !== 1'b1) begin
            fails++;
            $display("[TB] FAIL load_stall_idle: got %b expected 1", stall_req);
        end
        step();
        bubble();
        tests++;
        if ({dmem_req, dmem_we, dmem_addr, WriteRegSrc_out} !== {1'b1, 1'b0, 32'h40, 5'd0}) begin
            fails++;
            $display("[TB] FAIL load_req: got req=%b we=%b addr=%h wreg=%0d expected req=1 we=0 addr=40 wreg=0",
                     dmem_req, dmem_we, dmem_addr, WriteRegSrc_out);
        end
        for (int i = 1; i <= 3; i++) begin
            tests++;
            if (stall_req !== 1'b1) begin
                fails++;
                $display("[TB] FAIL load_stall_busy %0d: got %b expected 1", i, stall_req);
            end
            if (i == 3) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 32'hDEADBEEF;
            end
            step();
            dmem_ack = 1'b0;
        end
        tests++;
        if ({dmem_req, WriteDataSrc_out, ALURes_out, MemData_out, WriteRegSrc_out, stall_req} !==
            {1'b0, 2'b01, 32'h40, 32'hDEADBEEF, 5'd8, 1'b0}) begin
            fails++;
            $display("[TB] FAIL load_done: got req=%b wsrc=%h alu=%h mem=%h wreg=%0d stall=%b expected req=0 wsrc=1 alu=40 mem=deadbeef wreg=8 stall=0",
                     dmem_req, WriteDataSrc_out, ALURes_out, MemData_out, WriteRegSrc_out, stall_req);
        end
    endtask

    task automatic test_store();
        DataMemWE   = 1'b1;
        ALURes      = 32'h80;
        Reg2DataOut = 32'hCAFEF00D;
        step();
        bubble();
        tests++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 32'h80, 32'hCAFEF00D}) begin
            fails++;
            $display("[TB] FAIL store_req: got req=%b we=%b addr=%h wdata=%h expected req=1 we=1 addr=80 wdata=cafef00d",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_2222;
        step();
        dmem_ack = 1'b0;
        tests++;
        if ({dmem_req, stall_req, MemData_out, ALURes_out} !== {1'b0, 1'b0, 32'h0, 32'h80}) begin
            fails++;
            $display("[TB] FAIL store_done: got req=%b stall=%b mem=%h alu=%h expected req=0 stall=0 mem=0 alu=80",
                     dmem_req, stall_req, MemData_out, ALURes_out);
        end
    endtask

    task automatic test_timeout();
        int reqCycles = 0;
        WriteDataSrc = 2'b01;
        ALURes       = 32'h200;
        WriteRegSrc  = 5'd9;
        step();
        bubble();
        for (int i = 0; i < TO + 4; i++) begin
            if (bus_err) break;
            if (dmem_req) reqCycles++;
            step();
        end
        tests++;
        if (reqCycles !== TO) begin
            fails++;
            $display("[TB] FAIL timeout_req_cycles: got %0d expected %0d", reqCycles, TO);
        end
        tests++;
        if ({bus_err, dmem_req, WriteRegSrc_out, ALURes_out, MemData_out} !== {1'b1, 1'b0, 5'd0, 32'h0, 32'h0}) begin
            fails++;
            $display("[TB] FAIL timeout_abort: got berr=%b req=%b wreg=%0d alu=%h mem=%h expected berr=1 req=0 wreg=0 alu=0 mem=0",
                     bus_err, dmem_req, WriteRegSrc_out, ALURes_out, MemData_out);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1234_5678;
        step();
        dmem_ack = 1'b0;
        tests++;
        if ({bus_err, dmem_req, stall_req, WriteRegSrc_out, MemData_out} !== {1'b0, 1'b0, 1'b0, 5'd0, 32'h0}) begin
            fails++;
            $display("[TB] FAIL timeout_late_ack: got berr=%b req=%b stall=%b wreg=%0d mem=%h expected all 0",
                     bus_err, dmem_req, stall_req, WriteRegSrc_out, MemData_out);
        end
    endtask

    task automatic test_misaligned();
        WriteDataSrc = 2'b01;
        ALURes       = 32'h42;
        WriteRegSrc  = 5'd7;
        #1;
        tests++;
        if (stall_req !== 1'b0) begin
            fails++;
            $display("[TB] FAIL misalign_stall: got %b expected 0", stall_req);
        end
        step();
        bubble();
        tests++;
        if ({align_err, dmem_req, WriteRegSrc_out} !== {1'b1, 1'b0, 5'd0}) begin
            fails++;
            $display("[TB] FAIL misalign_pulse: got aerr=%b req=%b wreg=%0d expected aerr=1 req=0 wreg=0",
                     align_err, dmem_req, WriteRegSrc_out);
        end
        step();
        tests++;
        if ({align_err, dmem_req} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL misalign_one_cycle: got aerr=%b req=%b expected 0 0", align_err, dmem_req);
        end
    endtask

    task automatic test_mid_reset();
        WriteDataSrc = 2'b01;
        ALURes       = 32'h300;
        WriteRegSrc  = 5'd10;
        step();
        bubble();
        tests++;
        if (dmem_req !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midrst_req: got %b expected 1", dmem_req);
        end
        rst = 1'b0;
        step();
        tests++;
        if ({dmem_req, stall_req} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL midrst_abort: got req=%b stall=%b expected 0 0", dmem_req, stall_req);
        end
        rst        = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hAAAA_5555;
        step();
        dmem_ack = 1'b0;
        tests++;
        if ({dmem_req, WriteRegSrc_out, MemData_out} !== {1'b0, 5'd0, 32'h0}) begin
            fails++;
            $display("[TB] FAIL midrst_stale_ack: got req=%b wreg=%0d mem=%h expected 0 0 0",
                     dmem_req, WriteRegSrc_out, MemData_out);
        end
    endtask

    // Random transaction stream; each is launched right after the previous
    // completes, so back-to-back accesses and the one-cycle error pulses are
    // exercised. The model works per transaction: kind, ack delay k (in
    // cycles after the request edge), and the timeout limit decide the result.
    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            int          kind;
            int          k;
            logic        we;
            logic [1:0]  src;
            logic [31:0] addr;
            logic [31:0] wdata;
            logic [31:0] rdata;
            logic [4:0]  wreg;
            kind  = int'($urandom_range(0, 3));
            k     = int'($urandom_range(1, TO + 2));
            addr  = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            wreg  = 5'($urandom);
            we    = 1'b0;
            src   = 2'b00;
            case (kind)
                0: begin
                    src = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
                end
                1: begin
                    src  = 2'b01;
                    addr = {addr[31:2], 2'b00};
                end
                2: begin
                    we   = 1'b1;
                    src  = 2'($urandom);
                    addr = {addr[31:2], 2'b00};
                end
                default: begin
                    we = 1'($urandom);
                    if (!we) src = 2'b01;
                    if (addr[1:0] == 2'b00) addr[0] = 1'b1;
                end
            endcase

            DataMemWE    = we;
            WriteDataSrc = src;
            ALURes       = addr;
            Reg2DataOut  = wdata;
            WriteRegSrc  = wreg;
            #1;
            tests++;
            if (stall_req !== (kind == 1 || kind == 2)) begin
                fails++;
                $display("[TB] FAIL rnd_stall_idle #%0d kind %0d: got %b expected %b",
                         n, kind, stall_req, (kind == 1 || kind == 2));
            end
            step();

            if (kind == 0 || kind == 3) begin
                tests++;
                if ({WriteDataSrc_out, ALURes_out, MemData_out, WriteRegSrc_out, dmem_req, bus_err, align_err} !==
                    {src, addr, 32'h0, (kind == 3) ? 5'd0 : wreg, 1'b0, 1'b0, kind == 3}) begin
                    fails++;
                    $display("[TB] FAIL rnd_idle #%0d kind %0d: got wsrc=%h alu=%h mem=%h wreg=%0d req=%b berr=%b aerr=%b expected wsrc=%h alu=%h mem=0 wreg=%0d req=0 berr=0 aerr=%b",
                             n, kind, WriteDataSrc_out, ALURes_out, MemData_out, WriteRegSrc_out, dmem_req,
                             bus_err, align_err, src, addr, (kind == 3) ? 5'd0 : wreg, kind == 3);
                end
            end else begin
                tests++;
                if ({dmem_req, dmem_we, dmem_addr, WriteRegSrc_out, MemData_out, bus_err, align_err} !==
                    {1'b1, we, addr, 5'd0, 32'h0, 1'b0, 1'b0}) begin
                    fails++;
                    $display("[TB] FAIL rnd_issue #%0d: got req=%b we=%b addr=%h wreg=%0d mem=%h berr=%b aerr=%b expected req=1 we=%b addr=%h wreg=0 mem=0 errs=0",
                             n, dmem_req, dmem_we, dmem_addr, WriteRegSrc_out, MemData_out, bus_err, align_err, we, addr);
                end
                if (we) begin
                    tests++;
                    if (dmem_wdata !== wdata) begin
                        fails++;
                        $display("[TB] FAIL rnd_wdata #%0d: got %h expected %h", n, dmem_wdata, wdata);
                    end
                end
                for (int i = 1; i <= TO + 2; i++) begin
                    DataMemWE    = 1'($urandom);
                    WriteDataSrc = 2'($urandom);
                    ALURes       = $urandom;
                    Reg2DataOut  = $urandom;
                    WriteRegSrc  = 5'($urandom);
                    dmem_ack     = (i == k);
                    dmem_rdata   = (i == k) ? rdata : $urandom;
                    #1;
                    tests++;
                    if (stall_req !== 1'b1) begin
                        fails++;
                        $display("[TB] FAIL rnd_stall_busy #%0d cycle %0d: got %b expected 1", n, i, stall_req);
                    end
                    step();
                    dmem_ack = 1'b0;
                    if (i == k) begin
                        tests++;
                        if ({dmem_req, WriteDataSrc_out, ALURes_out, MemData_out, WriteRegSrc_out, bus_err, align_err} !==
                            {1'b0, src, addr, we ? 32'h0 : rdata, wreg, 1'b0, 1'b0}) begin
                            fails++;
                            $display("[TB] FAIL rnd_done #%0d k=%0d: got req=%b wsrc=%h alu=%h mem=%h wreg=%0d berr=%b aerr=%b expected req=0 wsrc=%h alu=%h mem=%h wreg=%0d errs=0",
                                     n, k, dmem_req, WriteDataSrc_out, ALURes_out, MemData_out, WriteRegSrc_out,
                                     bus_err, align_err, src, addr, we ? 32'h0 : rdata, wreg);
                        end
                        break;
                    end else if (i == TO) begin
                        tests++;
                        if ({dmem_req, WriteDataSrc_out, ALURes_out, MemData_out, WriteRegSrc_out, bus_err, align_err} !==
                            {1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0}) begin
                            fails++;
                            $display("[TB] FAIL rnd_timeout #%0d: got req=%b wsrc=%h alu=%h mem=%h wreg=%0d berr=%b aerr=%b expected req=0 wb=0 berr=1 aerr=0",
                                     n, dmem_req, WriteDataSrc_out, ALURes_out, MemData_out, WriteRegSrc_out, bus_err, align_err);
                        end
                        break;
                    end else begin
                        tests++;
                        if ({dmem_req, dmem_addr, WriteRegSrc_out, MemData_out, bus_err} !==
                            {1'b1, addr, 5'd0, 32'h0, 1'b0}) begin
                            fails++;
                            $display("[TB] FAIL rnd_wait #%0d cycle %0d: got req=%b addr=%h wreg=%0d mem=%h berr=%b expected req=1 addr=%h wreg=0 mem=0 berr=0",
                                     n, i, dmem_req, dmem_addr, WriteRegSrc_out, MemData_out, bus_err, addr);
                        end
                    end
                end
            end
        end
        bubble();
        step();
    endtask

    initial begin
        bubble();
        rst        = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        test_reset();
        test_alu_pass();
        test_load();
        test_store();
        test_timeout();
        test_misaligned();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
